data_axi_lite_master: RTL and testbench

- Data-side AXI4-Lite master for the MEM stage. Converts one load/store request into a single AXI-Lite read or write transaction.
- Holds the pipeline through stall_req until the transaction completes, then presents the load word for the MEM/WB pipeline register to capture.
- One transaction outstanding at a time. Flushes are honoured without aborting bus transactions.

---
 rtl/data_axi_lite_master.sv | 203 ++++++++++++++++++++
 tb/tb_data_axi_lite_master.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_axi_lite_master.sv
// Data-side AXI4-Lite master: one MEM-stage load/store becomes one AXI-Lite read or write; load word is valid in RESP, 3 stall cycles after the request against a zero-wait slave.
// Stalls the pipeline via stall_req while any channel waits on the slave; flushed transactions still finish on the bus and are dropped.
module data_axi_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic                  mem_write_en,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_write_data,
    input  logic [DATA_W/8-1:0]   mem_byte_sel,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  stall_req,
    output logic [DATA_W-1:0]     mem_read_data,
    output logic                  bus_error,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                drain_q, drain_d;
    logic                arvalid_q, arvalid_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                rready_q, rready_d;
    logic                bready_q, bready_d;

    // Accesses are word-aligned on the bus; byte lanes are selected by wstrb.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^mem_addr[1:0];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        drain_d   = drain_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        rready_d  = rready_q;
        bready_d  = bready_q;

        unique case (state_q)
            IDLE: begin
                if (mem_req && !flush) begin
                    addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
                    wdata_d = mem_write_data;
                    strb_d  = mem_byte_sel;
                    if (mem_write_en) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                if (flush) drain_d = 1'b1;
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (flush) drain_d = 1'b1;
                if (m_rvalid) begin
                    rready_d = 1'b0;
                    if (drain_q || flush) begin
                        // Flushed load: bus beat consumed, result thrown away.
                        drain_d = 1'b0;
                        err_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        rdata_d = m_rdata;
                        err_d   = (m_rresp != 2'b00);
                        state_d = RESP;
                    end
                end
            end
            WR: begin
                if (flush) drain_d = 1'b1;
                if (m_awready) awvalid_d = 1'b0;
                if (m_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (flush) drain_d = 1'b1;
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    if (drain_q || flush) begin
                        drain_d = 1'b0;
                        err_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        err_d   = (m_bresp != 2'b00);
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                // Leaving RESP is the edge the pipeline advances on, so the request is not relaunched.
                if (!hold || flush) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            drain_q   <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            drain_q   <= drain_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            rready_q  <= rready_d;
            bready_q  <= bready_d;
        end
    end

    assign stall_req     = mem_req && (state_q != RESP);
    assign mem_read_data = rdata_q;
    assign bus_error     = err_q;

    assign m_awaddr  = addr_q;
    assign m_awprot  = 3'b000;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = strb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_araddr  = addr_q;
    assign m_arprot  = 3'b000;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule

// File: tb/tb_data_axi_lite_master.sv
// Bench for data_axi_lite_master: a delay-programmable AXI-Lite slave plus a pipeline-side driver.
// Expected latency, data and error come from the transaction rules, not from the RTL structure.
`timescale 1ns/1ps
module tb_data_axi_lite_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_write_en, hold, flush;
    logic [31:0] mem_addr, mem_write_data;
    logic [3:0]  mem_byte_sel;
    logic        stall_req, bus_error;
    logic [31:0] mem_read_data;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
    logic        m_bvalid = 1'b0, m_rvalid = 1'b0;
    logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
    logic [31:0] m_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave behaviour knobs and the model's view of the last captured load word.
    int          cfg_ar = 0, cfg_aw = 0, cfg_w = 0, cfg_r = 0, cfg_b = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
    logic [31:0] mdl_rdata = '0;

    data_axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_byte_sel(mem_byte_sel),
        .hold(hold), .flush(flush),
        .stall_req(stall_req), .mem_read_data(mem_read_data), .bus_error(bus_error),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    // Handshakes are observed mid-cycle and consumed by the slave after the next edge.
    bit ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0;
    always @(negedge clk) begin
        ar_hs = m_arvalid && m_arready;
        aw_hs = m_awvalid && m_awready;
        w_hs  = m_wvalid && m_wready;
        r_hs  = m_rvalid && m_rready;
        b_hs  = m_bvalid && m_bready;
    end

    int ar_wt = 0, aw_wt = 0, w_wt = 0, r_wt = 0, b_wt = 0;
    bit r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
            m_rdata = '0; m_rresp = 2'b00; m_bresp = 2'b00;
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            ar_wt = 0; aw_wt = 0; w_wt = 0; r_wt = 0; b_wt = 0;
        end else begin
            if (r_hs) r_pend = 0;
            if (ar_hs) begin r_pend = 1; r_wt = 0; end
            if (b_hs) b_pend = 0;
            if (aw_hs) aw_got = 1;
            if (w_hs)  w_got = 1;
            if (aw_got && w_got) begin b_pend = 1; b_wt = 0; aw_got = 0; w_got = 0; end
            if (m_arvalid) begin m_arready = (ar_wt >= cfg_ar); ar_wt++; end else begin m_arready = 0; ar_wt = 0; end
            if (m_awvalid) begin m_awready = (aw_wt >= cfg_aw); aw_wt++; end else begin m_awready = 0; aw_wt = 0; end
            if (m_wvalid)  begin m_wready  = (w_wt >= cfg_w);   w_wt++;  end else begin m_wready  = 0; w_wt = 0;  end
            m_rvalid = r_pend && (r_wt >= cfg_r);
            if (r_pend) r_wt++;
            m_rdata = m_rvalid ? cfg_rdata : 32'h0;
            m_rresp = m_rvalid ? cfg_rresp : 2'b00;
            m_bvalid = b_pend && (b_wt >= cfg_b);
            if (b_pend) b_wt++;
            m_bresp = m_bvalid ? cfg_bresp : 2'b00;
        end
    end

    // Request-to-RESP stall cycles: one IDLE cycle, then each channel phase lasts its slave delay + 1.
    function automatic int exp_dur(input bit we);
        int mx;
        mx = (cfg_aw > cfg_w) ? cfg_aw : cfg_w;
        return we ? (3 + mx + cfg_b) : (3 + cfg_ar + cfg_r);
    endfunction

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] sel,
                          input int hold_cyc, input bit exit_by_flush, input string tag);
        int          stalls, exp_stalls;
        bit          aw_done, w_done, ar_done, r_done, reached;
        logic [31:0] exp_addr, exp_data;
        logic        exp_err;
        stalls = 0; aw_done = 0; w_done = 0; ar_done = 0; r_done = 0; reached = 0;
        exp_addr   = {addr[31:2], 2'b00};
        exp_stalls = exp_dur(we);
        exp_data   = we ? mdl_rdata : cfg_rdata;
        exp_err    = we ? (cfg_bresp != 2'b00) : (cfg_rresp != 2'b00);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #2;
            mem_req = 1; mem_write_en = we; mem_addr = addr; mem_write_data = wd; mem_byte_sel = sel;
            hold = 0; flush = 0;
            #1;
            if (stall_req === 1'b0) begin reached = 1; break; end
            stalls++;
            if (m_arvalid) begin
                n_checks++;
                if (we || m_araddr !== exp_addr || m_arprot !== 3'b000) begin
                    n_fail++; $display("FAIL %s ar_chan: we=%0b araddr=%h prot=%0d want load araddr=%h prot=0", tag, we, m_araddr, m_arprot, exp_addr);
                end
            end
            if (m_awvalid) begin
                n_checks++;
                if (!we || aw_done || m_awaddr !== exp_addr || m_awprot !== 3'b000) begin
                    n_fail++; $display("FAIL %s aw_chan: we=%0b done=%0b awaddr=%h want store awaddr=%h", tag, we, aw_done, m_awaddr, exp_addr);
                end
            end
            if (m_wvalid) begin
                n_checks++;
                if (!we || w_done || m_wdata !== wd || m_wstrb !== sel) begin
                    n_fail++; $display("FAIL %s w_chan: done=%0b wdata=%h wstrb=%b want wdata=%h wstrb=%b", tag, w_done, m_wdata, m_wstrb, wd, sel);
                end
            end
            if (m_bready) begin
                n_checks++;
                if (!(aw_done && w_done)) begin
                    n_fail++; $display("FAIL %s bready_early: got bready=1 with aw_done=%0b w_done=%0b want both 1", tag, aw_done, w_done);
                end
            end
            if (ar_done && !r_done) begin
                n_checks++;
                if (m_rready !== 1'b1) begin
                    n_fail++; $display("FAIL %s rready: got %b want 1", tag, m_rready);
                end
            end
            if (m_arvalid && m_arready) ar_done = 1;
            if (m_rvalid && m_rready)   r_done = 1;
            if (m_awvalid && m_awready) aw_done = 1;
            if (m_wvalid && m_wready)   w_done = 1;
        end
        n_checks++;
        if (!reached) begin
            n_fail++; $display("FAIL %s timeout: no RESP within 200 cycles, want RESP", tag);
            mem_req = 0;
            return;
        end
        if (stalls != exp_stalls) begin
            n_fail++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, exp_stalls);
        end
        n_checks++;
        if (mem_read_data !== exp_data) begin
            n_fail++; $display("FAIL %s resp_data: got %h want %h", tag, mem_read_data, exp_data);
        end
        n_checks++;
        if (bus_error !== exp_err) begin
            n_fail++; $display("FAIL %s resp_err: got %b want %b", tag, bus_error, exp_err);
        end
        if (!we) mdl_rdata = cfg_rdata;
        hold  = (hold_cyc > 0) || exit_by_flush;
        flush = (hold_cyc == 0) && exit_by_flush;
        for (int h = 1; h <= hold_cyc; h++) begin
            @(posedge clk); #2;
            hold  = (h < hold_cyc) || exit_by_flush;
            flush = (h == hold_cyc) && exit_by_flush;
            #1;
            n_checks++;
            if (stall_req !== 1'b0 || mem_read_data !== exp_data || bus_error !== exp_err || m_arvalid !== 1'b0 || m_awvalid !== 1'b0) begin
                n_fail++; $display("FAIL %s hold_resp: stall=%b data=%h err=%b arv=%b awv=%b want 0 %h %b 0 0", tag, stall_req, mem_read_data, bus_error, m_arvalid, m_awvalid, exp_data, exp_err);
            end
        end
        @(posedge clk); #2;
        mem_req = 0; hold = 0; flush = 0;
        #1;
        n_checks++;
        if (bus_error !== 1'b0 || stall_req !== 1'b0 || mem_read_data !== exp_data || m_arvalid !== 1'b0 || m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin
            n_fail++; $display("FAIL %s after_resp: err=%b stall=%b data=%h arv=%b awv=%b wv=%b want 0 0 %h 0 0 0", tag, bus_error, stall_req, mem_read_data, m_arvalid, m_awvalid, m_wvalid, exp_data);
        end
    endtask

    // Flush the first request at stall cycle k, then present a store back-to-back while the bus drains.
    task automatic run_drain(input bit we1, input logic [31:0] addr1, input int k,
                             input logic [31:0] addr2, input logic [31:0] wd2, input logic [3:0] sel2,
                             input int hold2, input string tag);
        bit done, finished, ar_done, r_done;
        finished = 0; ar_done = 0; r_done = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #2;
            hold = 0;
            if (c <= k) begin
                mem_req = 1; mem_write_en = we1; mem_addr = addr1; mem_write_data = 32'h5a5a_1234; mem_byte_sel = 4'hf;
                flush = (c == k);
            end else begin
                mem_req = 1; mem_write_en = 1; mem_addr = addr2; mem_write_data = wd2; mem_byte_sel = sel2;
                flush = 0;
            end
            #1;
            if (c >= k) begin
                n_checks++;
                if (stall_req !== 1'b1 || mem_read_data !== mdl_rdata || bus_error !== 1'b0) begin
                    n_fail++; $display("FAIL %s drain: stall=%b data=%h err=%b want 1 %h 0", tag, stall_req, mem_read_data, bus_error, mdl_rdata);
                end
            end
            if (c > k && !we1) begin
                n_checks++;
                if (m_awvalid !== 1'b0) begin
                    n_fail++; $display("FAIL %s drain_launch: awvalid=%b want 0", tag, m_awvalid);
                end
            end
            if (ar_done && !r_done) begin
                n_checks++;
                if (m_rready !== 1'b1) begin
                    n_fail++; $display("FAIL %s drain_rready: got %b want 1", tag, m_rready);
                end
            end
            if (m_arvalid && m_arready) ar_done = 1;
            if (m_rvalid && m_rready) r_done = 1;
            done = we1 ? (m_bvalid && m_bready) : (m_rvalid && m_rready);
            if (done && c >= k) begin finished = 1; break; end
        end
        n_checks++;
        if (!finished) begin
            n_fail++; $display("FAIL %s drain_timeout: bus transaction did not complete, want completion", tag);
            mem_req = 0; flush = 0;
            return;
        end
        do_req(1'b1, addr2, wd2, sel2, hold2, 1'b0, {tag, "_next"});
    endtask

    task automatic test_reset();
        @(posedge clk); #3;
        n_checks++;
        if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_handshake: got %b want 00000", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready});
        end
        n_checks++;
        if (mem_read_data !== 32'h0 || bus_error !== 1'b0 || stall_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: data=%h err=%b stall=%b want 0 0 0", mem_read_data, bus_error, stall_req);
        end
        n_checks++;
        if (m_araddr !== 32'h0 || m_wdata !== 32'h0 || m_wstrb !== 4'h0) begin
            n_fail++; $display("FAIL reset_regs: addr=%h wdata=%h wstrb=%b want 0", m_araddr, m_wdata, m_wstrb);
        end
        #1;
        rst = 1;
        mdl_rdata = 0;
    endtask

    task automatic test_load_zero_wait();
        cfg_ar = 0; cfg_r = 0; cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b00;
        do_req(1'b0, 32'h8000_0104, 32'h0, 4'h0, 0, 1'b0, "load_zero_wait");
    endtask

    task automatic test_store_w_first();
        cfg_aw = 2; cfg_w = 0; cfg_b = 0; cfg_bresp = 2'b00;
        do_req(1'b1, 32'h8000_0203, 32'h0000_AB00, 4'b0010, 0, 1'b0, "store_w_first");
    endtask

    task automatic test_read_error();
        cfg_ar = 1; cfg_r = 0; cfg_rdata = 32'h1357_9BDF; cfg_rresp = 2'b10;
        do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 1'b0, "read_error");
    endtask

    task automatic test_hold();
        cfg_ar = 0; cfg_r = 1; cfg_rdata = 32'hCAFE_F00D; cfg_rresp = 2'b00;
        do_req(1'b0, 32'h0000_1008, 32'h0, 4'h0, 3, 1'b0, "hold_resp");
        do_req(1'b0, 32'h0000_100c, 32'h0, 4'h0, 1, 1'b1, "hold_flush_exit");
    endtask

    task automatic test_flush_idle();
        @(posedge clk); #2;
        mem_req = 1; mem_write_en = 0; mem_addr = 32'h0000_2000; flush = 1; hold = 0;
        #1;
        n_checks++;
        if (stall_req !== 1'b1) begin
            n_fail++; $display("FAIL flush_idle_stall: got %b want 1", stall_req);
        end
        @(posedge clk); #2;
        mem_req = 0; flush = 0;
        #1;
        n_checks++;
        if (m_arvalid !== 1'b0 || m_awvalid !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle_launch: arvalid=%b awvalid=%b want 0 0", m_arvalid, m_awvalid);
        end
    endtask

    task automatic test_flush_drain();
        cfg_ar = 0; cfg_r = 4; cfg_rdata = 32'h0BAD_0BAD; cfg_rresp = 2'b00;
        cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_bresp = 2'b00;
        run_drain(1'b0, 32'h8000_0300, 2, 32'h8000_0310, 32'h1122_3344, 4'b1111, 0, "flush_rd_data");
        cfg_aw = 1; cfg_w = 2; cfg_b = 2; cfg_bresp = 2'b11;
        run_drain(1'b1, 32'h8000_0400, exp_dur(1'b1) - 1, 32'h8000_0404, 32'h00FF_0000, 4'b0100, 1, "flush_wr_resp");
    endtask

    task automatic test_async_reset();
        bit seen;
        seen = 0;
        cfg_aw = 0; cfg_w = 1; cfg_b = 10; cfg_bresp = 2'b00;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            mem_req = 1; mem_write_en = 1; mem_addr = 32'h0000_0500; mem_write_data = 32'hA5A5_A5A5; mem_byte_sel = 4'hf;
            hold = 0; flush = 0;
            #1;
            if (m_bready === 1'b1) begin seen = 1; break; end
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL reset_reach_wr_resp: bready never seen, want 1");
        end
        @(posedge clk); #2;
        rst = 0; mem_req = 0;
        #1;
        n_checks++;
        if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 5'b0 || stall_req !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_outputs: vr=%b stall=%b want 00000 0", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, stall_req);
        end
        n_checks++;
        if (mem_read_data !== 32'h0 || bus_error !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_data: data=%h err=%b want 0 0", mem_read_data, bus_error);
        end
        mdl_rdata = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1;
        cfg_ar = 0; cfg_r = 0; cfg_rdata = 32'h7777_0001; cfg_rresp = 2'b00;
        do_req(1'b0, 32'h0000_0600, 32'h0, 4'h0, 0, 1'b0, "after_reset_load");
    endtask

    task automatic test_random();
        bit          we;
        logic [31:0] addr, wd, addr2, wd2;
        logic [3:0]  sel, sel2;
        int          hc, k;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(1, 0));
            addr = $urandom; wd = $urandom; sel = 4'($urandom_range(15, 1));
            cfg_ar = $urandom_range(3, 0); cfg_aw = $urandom_range(3, 0); cfg_w = $urandom_range(3, 0);
            cfg_r = $urandom_range(3, 0); cfg_b = $urandom_range(3, 0);
            cfg_rdata = $urandom;
            cfg_rresp = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            cfg_bresp = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            hc = $urandom_range(2, 0);
            if (i % 4 == 3) begin
                k = $urandom_range(exp_dur(we) - 1, 1);
                addr2 = $urandom; wd2 = $urandom; sel2 = 4'($urandom_range(15, 1));
                run_drain(we, addr, k, addr2, wd2, sel2, hc, $sformatf("rand_drain_%0d", i));
            end else begin
                do_req(we, addr, wd, sel, hc, 1'($urandom_range(1, 0)), $sformatf("rand_%0d", i));
            end
        end
    endtask

    initial begin
        rst = 0; mem_req = 0; mem_write_en = 0; mem_addr = '0; mem_write_data = '0;
        mem_byte_sel = '0; hold = 0; flush = 0;
        test_reset();
        test_load_zero_wait();
        test_store_w_first();
        test_read_error();
        test_hold();
        test_flush_idle();
        test_flush_drain();
        test_async_reset();
        test_random();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, want completion");
        $fatal(1, "watchdog");
    end
endmodule
